// File: rtl/spram_pattern_tester.sv
// rtl/spram_pattern_tester.sv - LFSR write/read-back pattern tester driving one iCE40 SB_SPRAM256KA
// Optional write-data fault injection input: SPRAM_TESTER_INJECT_EN

module spram_pattern_tester #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          ERR_WIDTH  = 16,
  parameter int          LOOP       = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
`ifdef SPRAM_TESTER_INJECT_EN
  input  logic                  inject,
`endif
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [15:0]           ram_datain,
  output logic [3:0]            ram_maskwren,
  output logic                  ram_wren,
  output logic                  ram_chipselect,
  input  logic [15:0]           ram_dataout,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ERR_WIDTH-1:0]  error_count,
  output logic [15:0]           pass_count
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_END} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic                  parity_q, parity_d;
  logic                  stop_q, stop_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [ERR_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [15:0]           pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           din_q, din_d;
  logic [3:0]            mask_q, mask_d;
  logic                  wren_q, wren_d;
  logic                  cs_q, cs_d;
  logic [15:0]           exp1_q, exp1_d, exp2_q;
  logic                  vld1_q, vld1_d, vld2_q;

  logic                  last_addr, stop_pending, loop_on, inj;
  logic                  launch_wr, wr_parity;
  logic [15:0]           lfsr_step;

  assign last_addr    = (cnt_q == {ADDR_WIDTH{1'b1}});
  assign stop_pending = stop_q | stop;
  assign loop_on      = (LOOP != 0) && !stop_pending;
  assign lfsr_step    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

`ifdef SPRAM_TESTER_INJECT_EN
  assign inj = inject;
`else
  assign inj = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)     state_d = S_WRITE;
      S_WRITE: if (last_addr) state_d = S_READ;
      S_READ:  if (last_addr) state_d = S_DRAIN;
      S_DRAIN: if (cnt_q[0])  state_d = S_END;
      S_END:   state_d = loop_on ? S_WRITE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Every ram_* value is computed here and registered, so the pins change only on clk.
  always_comb begin
    launch_wr = 1'b0;
    wr_parity = parity_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    parity_d  = parity_q;
    stop_d    = stop_q | (busy_q & stop);
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    addr_d    = '0;
    din_d     = '0;
    mask_d    = '0;
    wren_d    = 1'b0;
    cs_d      = 1'b0;
    exp1_d    = exp1_q;
    vld1_d    = 1'b0;
    error_d   = error_q;
    err_cnt_d = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d    = 1'b1;
          launch_wr = 1'b1;
        end
      end
      S_WRITE: launch_wr = 1'b1;
      S_READ: begin
        cs_d   = 1'b1;
        addr_d = cnt_q;
        exp1_d = lfsr_q ^ {16{parity_q}};
        vld1_d = 1'b1;
        lfsr_d = last_addr ? SEED : lfsr_step;
        cnt_d  = cnt_q + 1'b1;
      end
      S_DRAIN: cnt_d = cnt_q[0] ? '0 : cnt_q + 1'b1;
      S_END: begin
        done_d   = 1'b1;
        pass_d   = pass_q + 1'b1;
        parity_d = ~parity_q;
        if (loop_on) begin
          launch_wr = 1'b1;
          wr_parity = ~parity_q;
        end else begin
          busy_d = 1'b0;
          stop_d = 1'b0;
        end
      end
      default: ;
    endcase

    // Address counter wraps to 0 after the last write, ready for the read sweep.
    if (launch_wr) begin
      cs_d   = 1'b1;
      wren_d = 1'b1;
      mask_d = 4'hF;
      addr_d = cnt_q;
      din_d  = lfsr_q ^ {16{wr_parity}} ^ {15'b0, inj};
      lfsr_d = last_addr ? SEED : lfsr_step;
      cnt_d  = cnt_q + 1'b1;
    end

    if (vld2_q && (ram_dataout != exp2_q)) begin
      error_d = 1'b1;
      if (err_cnt_q != {ERR_WIDTH{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      lfsr_q    <= SEED;
      parity_q  <= 1'b0;
      stop_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
      pass_q    <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      mask_q    <= '0;
      wren_q    <= 1'b0;
      cs_q      <= 1'b0;
      exp1_q    <= '0;
      exp2_q    <= '0;
      vld1_q    <= 1'b0;
      vld2_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      parity_q  <= parity_d;
      stop_q    <= stop_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
      pass_q    <= pass_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      mask_q    <= mask_d;
      wren_q    <= wren_d;
      cs_q      <= cs_d;
      exp1_q    <= exp1_d;
      exp2_q    <= exp1_q;
      vld1_q    <= vld1_d;
      vld2_q    <= vld1_q;
    end
  end

  assign ram_address    = addr_q;
  assign ram_datain     = din_q;
  assign ram_maskwren   = mask_q;
  assign ram_wren       = wren_q;
  assign ram_chipselect = cs_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign error_count    = err_cnt_q;
  assign pass_count     = pass_q;

endmodule
